// File: rtl/dcache_mshr.sv
// Dcache load responder: serves hits from the data array and tracks misses in a
// small MSHR file that issues block reads to memory and broadcasts fills to the LSQ.
//
// state         | meaning
// ST_EMPTY      | entry free, may be allocated
// ST_WAIT_ISSUE | miss recorded, block read not yet accepted by memory
// ST_WAIT_MEM   | memory accepted the read, waiting for data with the stored tag
module dcache_mshr #(
    parameter int ADDR_W     = 64,
    parameter int MSHR_NUM   = 4,
    parameter int MSHR_IDX_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lsq2Dcache_ld_addr_i,
    input  logic              lsq2Dcache_ld_en_i,
    input  logic              cache_hit_i,
    input  logic [63:0]       cache_rd_data_i,
    output logic              Dcache_hit_o,
    output logic [63:0]       Dcache_data_o,
    output logic [ADDR_W-1:0] Dcache_mshr_addr_o,
    output logic              Dcache_mshr_vld_o,
    output logic              Dcache_mshr_stall_o,
    output logic [1:0]        mshr2mem_command_o,
    output logic [ADDR_W-1:0] mshr2mem_addr_o,
    input  logic [3:0]        mem2mshr_response_i,
    input  logic [3:0]        mem2mshr_tag_i,
    input  logic [63:0]       mem2mshr_data_i,
    output logic              mshr2cache_wr_en_o,
    output logic [ADDR_W-1:0] mshr2cache_wr_addr_o,
    output logic [63:0]       mshr2cache_wr_data_o
);

    localparam logic [1:0] ST_EMPTY      = 2'd0;
    localparam logic [1:0] ST_WAIT_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT_MEM   = 2'd2;

    localparam logic [1:0] CMD_NONE = 2'd0;
    localparam logic [1:0] CMD_LOAD = 2'd1;

    localparam logic [ADDR_W-1:0] BLK_MASK = {{(ADDR_W-3){1'b1}}, 3'b000};

    logic [1:0]        r_state [MSHR_NUM];
    logic [ADDR_W-1:0] r_addr  [MSHR_NUM];
    logic [3:0]        r_tag   [MSHR_NUM];

    logic              r_vld;
    logic [ADDR_W-1:0] r_fill_addr;
    logic [63:0]       r_fill_data;

    logic [ADDR_W-1:0]     w_blk;
    logic                  w_merge;
    logic                  w_has_empty;
    logic [MSHR_IDX_W-1:0] w_alloc_idx;
    logic                  w_issue_vld;
    logic [MSHR_IDX_W-1:0] w_issue_idx;
    logic                  w_fill_vld;
    logic [MSHR_IDX_W-1:0] w_fill_idx;
    logic                  w_miss;
    logic                  w_alloc;
    logic                  w_issue_ack;

    assign w_blk = lsq2Dcache_ld_addr_i & BLK_MASK;

    // Scan from the top down so the lowest matching index wins each search.
    always_comb begin
        w_merge     = 1'b0;
        w_has_empty = 1'b0;
        w_alloc_idx = '0;
        w_issue_vld = 1'b0;
        w_issue_idx = '0;
        w_fill_vld  = 1'b0;
        w_fill_idx  = '0;
        for (int i = MSHR_NUM - 1; i >= 0; i--) begin
            if (r_state[i] != ST_EMPTY && r_addr[i] == w_blk) begin
                w_merge = 1'b1;
            end
            if (r_state[i] == ST_EMPTY) begin
                w_has_empty = 1'b1;
                w_alloc_idx = MSHR_IDX_W'(i);
            end
            if (r_state[i] == ST_WAIT_ISSUE) begin
                w_issue_vld = 1'b1;
                w_issue_idx = MSHR_IDX_W'(i);
            end
            if (r_state[i] == ST_WAIT_MEM && mem2mshr_tag_i != 4'd0 &&
                r_tag[i] == mem2mshr_tag_i) begin
                w_fill_vld = 1'b1;
                w_fill_idx = MSHR_IDX_W'(i);
            end
        end
    end

    // A broadcast cycle owns the response bus, so any load then must retry.
    assign w_miss      = lsq2Dcache_ld_en_i & ~cache_hit_i & ~r_vld;
    assign w_alloc     = w_miss & ~w_merge & w_has_empty;
    assign w_issue_ack = w_issue_vld & (mem2mshr_response_i != 4'd0);

    assign Dcache_hit_o        = lsq2Dcache_ld_en_i & cache_hit_i & ~r_vld;
    assign Dcache_data_o       = r_vld ? r_fill_data : cache_rd_data_i;
    assign Dcache_mshr_stall_o = lsq2Dcache_ld_en_i &
                                 (r_vld | (~cache_hit_i & ~w_merge & ~w_has_empty));

    assign mshr2mem_command_o = w_issue_vld ? CMD_LOAD : CMD_NONE;
    assign mshr2mem_addr_o    = w_issue_vld ? r_addr[w_issue_idx] : '0;

    assign Dcache_mshr_vld_o    = r_vld;
    assign Dcache_mshr_addr_o   = r_fill_addr;
    assign mshr2cache_wr_en_o   = r_vld;
    assign mshr2cache_wr_addr_o = r_fill_addr;
    assign mshr2cache_wr_data_o = r_fill_data;

    // Fill, issue and allocate always target distinct entries by state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MSHR_NUM; i++) begin
                r_state[i] <= ST_EMPTY;
                r_addr[i]  <= '0;
                r_tag[i]   <= '0;
            end
            r_vld       <= 1'b0;
            r_fill_addr <= '0;
            r_fill_data <= '0;
        end else begin
            r_vld <= w_fill_vld;
            if (w_fill_vld) begin
                r_fill_addr         <= r_addr[w_fill_idx];
                r_fill_data         <= mem2mshr_data_i;
                r_state[w_fill_idx] <= ST_EMPTY;
            end
            if (w_issue_ack) begin
                r_state[w_issue_idx] <= ST_WAIT_MEM;
                r_tag[w_issue_idx]   <= mem2mshr_response_i;
            end
            if (w_alloc) begin
                r_state[w_alloc_idx] <= ST_WAIT_ISSUE;
                r_addr[w_alloc_idx]  <= w_blk;
            end
        end
    end

endmodule

// File: tb/tb_dcache_mshr.sv
// Directed bench for dcache_mshr: hit path, miss round trip, merge, full,
// issue back-pressure, broadcast conflict and reset with a miss outstanding.
module tb_dcache_mshr;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] ld_addr;
    logic        ld_en;
    logic        cache_hit;
    logic [63:0] rd_data;
    logic        hit_o;
    logic [63:0] data_o;
    logic [63:0] mshr_addr_o;
    logic        mshr_vld_o;
    logic        stall_o;
    logic [1:0]  cmd_o;
    logic [63:0] mem_addr_o;
    logic [3:0]  resp;
    logic [3:0]  mtag;
    logic [63:0] mdata;
    logic        wr_en_o;
    logic [63:0] wr_addr_o;
    logic [63:0] wr_data_o;

    int n_vec = 0;
    int n_miscmp = 0;

    always #5 clk = ~clk;

    dcache_mshr #(.ADDR_W(64), .MSHR_NUM(4), .MSHR_IDX_W(2)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .lsq2Dcache_ld_addr_i (ld_addr),
        .lsq2Dcache_ld_en_i   (ld_en),
        .cache_hit_i          (cache_hit),
        .cache_rd_data_i      (rd_data),
        .Dcache_hit_o         (hit_o),
        .Dcache_data_o        (data_o),
        .Dcache_mshr_addr_o   (mshr_addr_o),
        .Dcache_mshr_vld_o    (mshr_vld_o),
        .Dcache_mshr_stall_o  (stall_o),
        .mshr2mem_command_o   (cmd_o),
        .mshr2mem_addr_o      (mem_addr_o),
        .mem2mshr_response_i  (resp),
        .mem2mshr_tag_i       (mtag),
        .mem2mshr_data_i      (mdata),
        .mshr2cache_wr_en_o   (wr_en_o),
        .mshr2cache_wr_addr_o (wr_addr_o),
        .mshr2cache_wr_data_o (wr_data_o)
    );

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ld_en     = 1'b0;
        cache_hit = 1'b0;
        resp      = 4'd0;
        mtag      = 4'd0;
    endtask

    task automatic load(input logic [63:0] a, input logic h, input logic [63:0] d);
        idle();
        ld_en     = 1'b1;
        ld_addr   = a;
        cache_hit = h;
        rd_data   = d;
    endtask

    task automatic chk_cmd(input string tag, input logic [1:0] c, input logic [63:0] a);
        check_vec({tag, "_cmd"}, cmd_o, c);
        check_vec({tag, "_maddr"}, mem_addr_o, a);
    endtask

    task automatic chk_bcast(input string tag, input logic [63:0] a, input logic [63:0] d);
        check_vec({tag, "_vld"}, mshr_vld_o, 1);
        check_vec({tag, "_addr"}, mshr_addr_o, a);
        check_vec({tag, "_data"}, data_o, d);
        check_vec({tag, "_wren"}, wr_en_o, 1);
        check_vec({tag, "_wraddr"}, wr_addr_o, a);
        check_vec({tag, "_wrdata"}, wr_data_o, d);
    endtask

    initial begin
        rst     = 1'b1;
        ld_addr = '0;
        rd_data = '0;
        mdata   = '0;
        idle();
        next_cyc();
        next_cyc();
        check_vec("rst_vld", mshr_vld_o, 0);
        check_vec("rst_wren", wr_en_o, 0);
        check_vec("rst_wraddr", wr_addr_o, 0);
        check_vec("rst_stall", stall_o, 0);
        chk_cmd("rst", 2'd0, 0);
        rst = 1'b0;

        next_cyc(); load(64'h40, 1'b1, 64'hDEAD); #1;
        check_vec("hit_hit", hit_o, 1);
        check_vec("hit_data", data_o, 64'hDEAD);
        check_vec("hit_stall", stall_o, 0);
        chk_cmd("hit", 2'd0, 0);

        // miss round trip
        next_cyc(); load(64'h4D, 1'b0, 64'hBAD); #1;
        check_vec("miss_hit", hit_o, 0);
        check_vec("miss_stall", stall_o, 0);
        next_cyc(); idle(); resp = 4'd3; #1;
        chk_cmd("miss_issue", 2'd1, 64'h48);
        next_cyc(); idle(); #1;
        chk_cmd("miss_wait", 2'd0, 0);
        repeat (3) next_cyc();
        next_cyc(); idle(); mtag = 4'd3; mdata = 64'h1234; #1;
        check_vec("miss_pre_vld", mshr_vld_o, 0);
        next_cyc(); idle(); mtag = 4'd5; #1;
        chk_bcast("miss_fill", 64'h48, 64'h1234);
        next_cyc(); idle(); #1;
        check_vec("stray_tag_vld", mshr_vld_o, 0);
        check_vec("stray_tag_wren", wr_en_o, 0);
        check_vec("after_fill_data", data_o, 64'hBAD);

        // merge of two misses to the same block
        next_cyc(); load(64'h48, 1'b0, 0); #1;
        check_vec("merge_a_stall", stall_o, 0);
        next_cyc(); load(64'h4F, 1'b0, 0); resp = 4'd2; #1;
        check_vec("merge_b_stall", stall_o, 0);
        chk_cmd("merge_issue", 2'd1, 64'h48);
        next_cyc(); idle(); #1;
        chk_cmd("merge_single", 2'd0, 0);
        next_cyc(); idle(); mtag = 4'd2; mdata = 64'h55;
        next_cyc(); idle(); #1;
        chk_bcast("merge_fill", 64'h48, 64'h55);
        next_cyc(); idle(); #1;
        check_vec("merge_one_bcast", mshr_vld_o, 0);

        // fill all entries; memory holds off the first issue for 3 cycles
        next_cyc(); load(64'h0, 1'b0, 0); #1;
        check_vec("full_a0_stall", stall_o, 0);
        next_cyc(); load(64'h8, 1'b0, 0); #1;
        check_vec("full_a1_stall", stall_o, 0);
        chk_cmd("bp_c1", 2'd1, 64'h0);
        next_cyc(); load(64'h10, 1'b0, 0); #1;
        chk_cmd("bp_c2", 2'd1, 64'h0);
        next_cyc(); load(64'h18, 1'b0, 0); #1;
        check_vec("full_a3_stall", stall_o, 0);
        chk_cmd("bp_c3", 2'd1, 64'h0);
        next_cyc(); load(64'h20, 1'b0, 0); resp = 4'd1; #1;
        check_vec("full_stall", stall_o, 1);
        chk_cmd("bp_c4", 2'd1, 64'h0);
        next_cyc(); idle(); resp = 4'd4; #1;
        chk_cmd("issue_e1", 2'd1, 64'h8);
        next_cyc(); idle(); resp = 4'd5; #1;
        chk_cmd("issue_e2", 2'd1, 64'h10);
        next_cyc(); idle(); resp = 4'd6; #1;
        chk_cmd("issue_e3", 2'd1, 64'h18);
        next_cyc(); load(64'h20, 1'b0, 0); #1;
        check_vec("full_again_stall", stall_o, 1);
        chk_cmd("no_5th_entry", 2'd0, 0);
        next_cyc(); load(64'h20, 1'b0, 0); mtag = 4'd1; mdata = 64'hAAAA; #1;
        check_vec("freed_not_alloc", stall_o, 1);
        next_cyc(); load(64'h20, 1'b1, 64'h777); #1;
        chk_bcast("full_fill", 64'h0, 64'hAAAA);
        check_vec("conflict_hit", hit_o, 0);
        check_vec("conflict_stall", stall_o, 1);
        next_cyc(); load(64'h20, 1'b0, 0); #1;
        check_vec("retry_stall", stall_o, 0);
        check_vec("retry_vld", mshr_vld_o, 0);
        next_cyc(); idle(); resp = 4'd7; #1;
        chk_cmd("retry_issue", 2'd1, 64'h20);
        next_cyc(); idle(); mtag = 4'd5; mdata = 64'h5555;
        next_cyc(); idle(); mtag = 4'd9; #1;
        chk_bcast("tag5_fill", 64'h10, 64'h5555);
        next_cyc(); idle(); mtag = 4'd4; #1;
        check_vec("tag9_ignored", mshr_vld_o, 0);
        next_cyc(); idle(); mtag = 4'd6;
        next_cyc(); idle(); mtag = 4'd7;
        next_cyc(); idle();

        // reset with a miss outstanding drops it
        next_cyc(); load(64'h105, 1'b0, 0);
        next_cyc(); idle(); resp = 4'd8; #1;
        chk_cmd("rstmid_issue", 2'd1, 64'h100);
        next_cyc(); idle(); rst = 1'b1;
        next_cyc(); rst = 1'b0; mtag = 4'd8; mdata = 64'h1;
        next_cyc(); idle(); #1;
        check_vec("rstmid_vld", mshr_vld_o, 0);
        check_vec("rstmid_wren", wr_en_o, 0);
        chk_cmd("rstmid_cmd", 2'd0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule

// File: doc/dcache_mshr.md
Name: dcache_mshr

Overview:
Dcache-side responder to the LSQ load-request interface. It receives load requests (address + enable) and answers hits from the cache data array. It tracks misses in a small miss-status holding register (MSHR) file, issues block reads to memory, and broadcasts returning fill data back to the LSQ together with the fill address. It also produces the cache-line write for the fill and the stall signal the LSQ uses to throttle load issue.

Parameters:
ADDR_W, 64, load address width
MSHR_NUM, 4, number of outstanding misses
MSHR_IDX_W, 2, log2(MSHR_NUM)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
lsq2Dcache_ld_addr_i  in  ADDR_W  load address from LSQ
lsq2Dcache_ld_en_i  in  1  load request valid
cache_hit_i  in  1  tag-array hit for lsq2Dcache_ld_addr_i (combinational lookup)
cache_rd_data_i  in  64  data-array read for lsq2Dcache_ld_addr_i
Dcache_hit_o  out  1  request hit, data valid this cycle
Dcache_data_o  out  64  hit data or fill data
Dcache_mshr_addr_o  out  ADDR_W  block address of fill being broadcast
Dcache_mshr_vld_o  out  1  fill broadcast valid
Dcache_mshr_stall_o  out  1  miss not accepted; LSQ must retry
mshr2mem_command_o  out  2  0=NONE, 1=LOAD
mshr2mem_addr_o  out  ADDR_W  memory request address (block aligned)
mem2mshr_response_i  in  4  nonzero = request accepted, value is its tag
mem2mshr_tag_i  in  4  nonzero = data returning for that tag
mem2mshr_data_i  in  64  returning block data
mshr2cache_wr_en_o  out  1  fill write to cache arrays
mshr2cache_wr_addr_o  out  ADDR_W  fill address
mshr2cache_wr_data_o  out  64  fill data

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst. Reset empties all MSHRs and clears every registered output: Dcache_mshr_vld_o=0, Dcache_mshr_addr_o=0, mshr2cache_wr_en_o=0, wr_addr=0, wr_data=0. Reset mid-miss drops outstanding misses; later memory tags for them are ignored.
- Block address: blk(a) = {a[ADDR_W-1:3],3'b0}. All matching, memory requests, and fill addresses use blk().
- Entry states: EMPTY -> WAIT_ISSUE -> WAIT_MEM -> EMPTY. Each entry holds blk address and a 4-bit mem tag.
- Hit path (combinational):
  - Dcache_hit_o = ld_en & cache_hit_i & ~Dcache_mshr_vld_o.
  - Dcache_data_o = fill data when Dcache_mshr_vld_o, else cache_rd_data_i.
- Miss classification: ld_en & ~cache_hit_i is a miss.
  - Merge: if blk(addr) matches a non-EMPTY entry, or matches the entry being filled this cycle, nothing is allocated and stall=0. The LSQ waits for the broadcast.
  - Allocate: otherwise, the lowest-index EMPTY entry -> WAIT_ISSUE at the next edge; stall=0.
  - Full: no EMPTY entry -> stall=1 and nothing is recorded.
  - An entry freed this cycle is not allocatable until the next cycle.
- Broadcast conflict: ld_en while Dcache_mshr_vld_o=1 -> stall=1, hit=0, no allocation.
- Dcache_mshr_stall_o is combinational from the current state and inputs.
- Memory issue:
  - Lowest-index WAIT_ISSUE entry drives command=LOAD and its block address; otherwise command=NONE, addr=0.
  - If mem2mshr_response_i != 0 in that cycle, the entry -> WAIT_MEM and stores the response as its tag.
  - If response == 0, the entry stays in WAIT_ISSUE and re-issues next cycle.
  - At most one issue per cycle.
- Fill:
  - When mem2mshr_tag_i != 0 matches a WAIT_MEM entry's tag, at the next edge that entry -> EMPTY.
  - In the same next cycle: Dcache_mshr_vld_o=1, Dcache_mshr_addr_o=entry addr, Dcache_data_o=mem2mshr_data_i (registered), mshr2cache_wr_en_o=1 with the same addr/data. These are 1-cycle pulses.
  - A tag matching no entry is ignored.
- Simultaneous events:
  - Issue, fill-tag match, and allocation may all occur in one cycle on different entries.
  - The issue response and a fill tag are independent.

Test Plan:
- Reset: hold rst 2 cycles -> mshr_vld=0, wr_en=0, command=0, stall=0, all entries EMPTY.
- Hit: ld_en=1, addr=0x40, cache_hit=1, rd_data=0xDEAD -> same cycle hit=1, data=0xDEAD, command=NONE.
- Miss round trip: ld_en, addr=0x4D, hit=0 -> next cycle command=LOAD, mem addr=0x48. Response=3 that cycle. Five cycles later mem tag=3, data=0x1234 -> next cycle mshr_vld=1, mshr_addr=0x48, data=0x1234, wr_en=1; entry EMPTY.
- Merge: misses to 0x48 then 0x4F in consecutive cycles -> one LOAD only, one broadcast, stall=0 both cycles.
- Full: 4 misses to 0x0, 0x8, 0x10, 0x18, then a miss to 0x20 -> stall=1, no 5th entry. After tag fill of 0x0, retry of 0x20 is accepted the following cycle.
- Response back-pressure and conflict: response=0 for 3 cycles -> LOAD held with the same addr for 4 cycles. Load during broadcast cycle -> hit=0, stall=1.
